seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, clocked successor to the single-cycle datapath ALU for the multi-cycle CPU.
- Keeps the same operand-select scheme: A is a register or the shift amount; B is a register or the immediate.
- Adds WIDTH generalisation, an iterative unsigned multiply/divide, and a start/busy/done handshake, so the control FSM can stall on long operations.
- Sits between the register file / immediate extender and the ALUOut register.

Parameters:
- WIDTH, 32, datapath width in bits (≥4).
- SHW, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- CLK  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- ALUOp  in  4  operation code, latched on accepted start
- ReadData1  in  WIDTH  register operand A
- sa  in  SHW  shift amount
- ReadData2  in  WIDTH  register operand B
- immediate  in  WIDTH  extended immediate
- ALUSrcA  in  1  0: opA=ReadData1; 1: opA=zero-extended sa
- ALUSrcB  in  1  0: opB=ReadData2; 1: opB=immediate
- busy  out  1  high while the operation is in progress (EXEC or ITER)
- done  out  1  one-cycle pulse; result valid from this cycle on
- result  out  WIDTH  primary result
- result_hi  out  WIDTH  product high word / remainder; 0 for single-cycle ops
- zero  out  1  result == 0
- sign  out  1  result[WIDTH-1]
- illegal  out  1  latched; set when the last op was an unsupported code

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE.
  - busy=0, done=0, result=0, result_hi=0, illegal=0.
  - zero=1, because it is derived from result.
  - Reset asserted mid-operation aborts the op; no done pulse is generated.
- Operand capture: opA and opB are selected combinationally and latched together with ALUOp when start=1 in IDLE. Later input changes have no effect on the running op.
- States:
  - IDLE: on start go to EXEC, busy=1.
  - EXEC: for single-cycle codes, compute, write result and result_hi, go to DONE. For codes 1000/1001, initialise the iteration counter to WIDTH and go to ITER.
  - ITER: one shift-add (mul) or one restoring-subtract (div) step per cycle; counter decrements; at 0 go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start while not in IDLE is ignored, not queued. start in the DONE cycle is ignored; the earliest re-issue is the cycle after done.
- Latency, with start accepted at edge N:
  - single-cycle op: done high during cycle N+2.
  - mul/div: done high during cycle N+WIDTH+2.
- Opcodes (all arithmetic modulo 2^WIDTH):
  - 0000 add: opA+opB
  - 0001 sub: opA-opB
  - 0010 sltu: unsigned opA<opB ? 1 : 0
  - 0011 slt: signed opA<opB ? 1 : 0
  - 0100 sll: opB << opA[SHW-1:0]
  - 0101 or
  - 0110 and
  - 0111 xnor
  - 1000 mulu: {result_hi,result} = opA*opB, full 2·WIDTH-bit product
  - 1001 divu: result = opA/opB, result_hi = opA%opB
  - 1010–1111: result=0, result_hi=0, illegal=1, single-cycle latency
- illegal is updated on every completed op: cleared by any legal op, set by an illegal one.
- Divide by zero: result = all ones, result_hi = opA, single-cycle latency (skips ITER), illegal=0.
- result, result_hi, zero and sign hold their values from done until the next op's done; they do not change during busy.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- Defined: opcode 1001 is implemented as specified above.
- Undefined:
  - No divider hardware is built.
  - 1001 is treated as illegal: result=0, result_hi=0, illegal=1, single-cycle latency.
  - The ITER path serves mulu only.

Test Plan (WIDTH=32):
- Reset: deassert Reset, then start add with ReadData1=5, ReadData2=7, ALUSrcA=ALUSrcB=0 → done at N+2; result=12, result_hi=0, zero=0, sign=0, illegal=0.
- Shift and signed compare:
  - sll, ALUSrcA=1, sa=4, ReadData2=0x1 → result=0x10.
  - slt, A=0xFFFFFFFF, B=1 → 1.
  - sltu on the same operands → 0.
- mulu: A=0xFFFFFFFF, B=2 → done at N+34; result=0xFFFFFFFE, result_hi=1; start pulses during busy are ignored (no extra done).
- divu, with SEQ_ALU_DIV_EN defined:
  - 100/7 → result=14, result_hi=2.
  - 9/0 → result=0xFFFFFFFF, result_hi=9, done at N+2.
  - Without the macro, 100/7 → result=0, illegal=1.
- Illegal code and reset abort:
  - ALUOp=1111 → illegal=1; a following add clears it.
  - Start mulu, assert Reset at cycle N+10 → outputs return to their reset values immediately; no done pulse.
- Operand hold: change ReadData1/2 during mulu busy → product equals that of the operands latched at start.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU with a start/busy/done handshake and iterative unsigned multiply.
// Define SEQ_ALU_DIV_EN to build the iterative divider (opcode 1001); without it, 1001 is illegal.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [SHW-1:0]   sa,
    input  logic [WIDTH-1:0] ReadData2,
    input  logic [WIDTH-1:0] immediate,
    input  logic             ALUSrcA,
    input  logic             ALUSrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             sign,
    output logic             illegal
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
    logic             ill_q, ill_d;

    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   mul_sum;
`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]   rem_sh, rem_diff;
`endif

    assign op_a = ALUSrcA ? {{(WIDTH-SHW){1'b0}}, sa} : ReadData1;
    assign op_b = ALUSrcB ? immediate : ReadData2;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            ill_q    <= ill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        ill_d    = ill_q;
        mul_sum  = '0;
`ifdef SEQ_ALU_DIV_EN
        rem_sh   = '0;
        rem_diff = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EXEC;
                    op_d    = ALUOp;
                    a_d     = op_a;
                    b_d     = op_b;
                end
            end
            S_EXEC: begin
                // Visible results only change when entering DONE, so they hold while busy.
                state_d  = S_DONE;
                res_hi_d = '0;
                ill_d    = 1'b0;
                unique case (op_q)
                    4'd0: res_d = a_q + b_q;
                    4'd1: res_d = a_q - b_q;
                    4'd2: res_d = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
                    4'd3: res_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                    4'd4: res_d = b_q << a_q[SHW-1:0];
                    4'd5: res_d = a_q | b_q;
                    4'd6: res_d = a_q & b_q;
                    4'd7: res_d = ~(a_q ^ b_q);
                    4'd8: begin
                        state_d  = S_ITER;
                        res_d    = res_q;
                        res_hi_d = res_hi_q;
                        ill_d    = ill_q;
                        hi_d     = '0;
                        lo_d     = b_q;
                        cnt_d    = CW'(WIDTH);
                    end
`ifdef SEQ_ALU_DIV_EN
                    4'd9: begin
                        if (b_q == '0) begin
                            res_d    = '1;
                            res_hi_d = a_q;
                        end else begin
                            state_d  = S_ITER;
                            res_d    = res_q;
                            res_hi_d = res_hi_q;
                            ill_d    = ill_q;
                            hi_d     = '0;
                            lo_d     = a_q;
                            cnt_d    = CW'(WIDTH);
                        end
                    end
`endif
                    default: begin
                        res_d = '0;
                        ill_d = 1'b1;
                    end
                endcase
            end
            S_ITER: begin
                cnt_d = cnt_q - CW'(1);
`ifdef SEQ_ALU_DIV_EN
                if (op_q == 4'd9) begin
                    // Restoring divide: hi holds the partial remainder, lo shifts dividend out and quotient in.
                    rem_sh = {hi_q, lo_q[WIDTH-1]};
                    if (rem_sh >= {1'b0, b_q}) begin
                        rem_diff = rem_sh - {1'b0, b_q};
                        hi_d     = rem_diff[WIDTH-1:0];
                        lo_d     = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d     = rem_sh[WIDTH-1:0];
                        lo_d     = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else
`endif
                begin
                    mul_sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
                    {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    res_d    = lo_d;
                    res_hi_d = hi_d;
                    ill_d    = 1'b0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q == S_EXEC) || (state_q == S_ITER);
    assign done      = (state_q == S_DONE);
    assign result    = res_q;
    assign result_hi = res_hi_q;
    assign zero      = (res_q == '0);
    assign sign      = res_q[WIDTH-1];
    assign illegal   = ill_q;

endmodule
